// File: rtl/operand_fetch.sv
// Issue stage in front of the 16-bit ALU: register file, scoreboard, hazard stall
// and a registered {in1, in2, op, rd} bundle presented over valid/ready.
module operand_fetch #(
  parameter int NREGS = 8,
  parameter int AW    = 3,
  parameter int IMM_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             in_valid,
  output logic             in_ready,
  input  logic [AW-1:0]    in_rs1,
  input  logic [AW-1:0]    in_rs2,
  input  logic [AW-1:0]    in_rd,
  input  logic [IMM_W-1:0] in_imm,
  input  logic             in_use_imm,
  input  logic [3:0]       in_op,

  output logic             alu_valid,
  input  logic             alu_ready,
  output logic [15:0]      alu_in1,
  output logic [15:0]      alu_in2,
  output logic [3:0]       alu_op,
  output logic [AW-1:0]    alu_rd,

  input  logic             wb_en,
  input  logic [AW-1:0]    wb_addr,
  input  logic [15:0]      wb_data
);

  logic [15:0]      rf [NREGS];
  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pending_nxt;

  logic [15:0] rd1;
  logic [15:0] rd2;
  logic [15:0] imm_ext;
  logic        wb_hit1;
  logic        wb_hit2;
  logic        haz1;
  logic        haz2;
  logic        hazard;
  logic        accept;
  logic        wb_wr;

  assign wb_wr   = wb_en && (wb_addr != '0);
  assign wb_hit1 = wb_en && (wb_addr == in_rs1);
  assign wb_hit2 = wb_en && (wb_addr == in_rs2);
  assign imm_ext = {{(16-IMM_W){in_imm[IMM_W-1]}}, in_imm};

  // Combinational reads with write-through of the value landing this cycle.
  always_comb begin
    rd1 = rf[in_rs1];
    if (in_rs1 == '0) begin
      rd1 = '0;
    end else if (wb_hit1) begin
      rd1 = wb_data;
    end
  end

  always_comb begin
    rd2 = rf[in_rs2];
    if (in_rs2 == '0) begin
      rd2 = '0;
    end else if (wb_hit2) begin
      rd2 = wb_data;
    end
  end

  // A result arriving this cycle resolves the dependency, so it does not stall.
  assign haz1     = pending[in_rs1] && !wb_hit1;
  assign haz2     = !in_use_imm && pending[in_rs2] && !wb_hit2;
  assign hazard   = haz1 || haz2;
  assign in_ready = !hazard && (!alu_valid || alu_ready);
  assign accept   = in_valid && in_ready;

  // Clear first, then set: the newly issued producer wins on a collision.
  always_comb begin
    pending_nxt = pending;
    if (wb_en) begin
      pending_nxt[wb_addr] = 1'b0;
    end
    if (accept && (in_rd != '0)) begin
      pending_nxt[in_rd] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        rf[i] <= '0;
      end
    end else if (wb_wr) begin
      rf[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_valid <= 1'b0;
      alu_in1   <= '0;
      alu_in2   <= '0;
      alu_op    <= '0;
      alu_rd    <= '0;
    end else if (accept) begin
      alu_valid <= 1'b1;
      alu_in1   <= rd1;
      alu_in2   <= in_use_imm ? imm_ext : rd2;
      alu_op    <= in_op;
      alu_rd    <= in_rd;
    end else if (alu_ready) begin
      alu_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed vectors, a behavioural model checked every
// cycle, plus literal expectations taken from hand-worked scenarios.
module tb_operand_fetch;

  localparam int NREGS = 8;
  localparam int AW    = 3;
  localparam int IMM_W = 8;
  localparam logic [3:0] FUNCT_ADD = 4'd0;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [AW-1:0]    in_rs1;
  logic [AW-1:0]    in_rs2;
  logic [AW-1:0]    in_rd;
  logic [IMM_W-1:0] in_imm;
  logic             in_use_imm;
  logic [3:0]       in_op;
  logic             alu_valid;
  logic             alu_ready;
  logic [15:0]      alu_in1;
  logic [15:0]      alu_in2;
  logic [3:0]       alu_op;
  logic [AW-1:0]    alu_rd;
  logic             wb_en;
  logic [AW-1:0]    wb_addr;
  logic [15:0]      wb_data;

  int checks = 0;
  int errors = 0;

  operand_fetch #(.NREGS(NREGS), .AW(AW), .IMM_W(IMM_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_op(in_op),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op), .alu_rd(alu_rd),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: architectural registers, outstanding-writer flags, bundle.
  logic [15:0] m_rf   [NREGS];
  bit          m_pend [NREGS];
  bit          m_valid;
  logic [15:0] m_in1;
  logic [15:0] m_in2;
  logic [3:0]  m_op;
  logic [AW-1:0] m_rd;

  function automatic logic [15:0] m_read(input int r);
    if (r == 0) return 16'h0000;
    if (wb_en && int'(wb_addr) == r) return wb_data;
    return m_rf[r];
  endfunction

  function automatic bit m_waiting(input int r);
    return r != 0 && m_pend[r] && !(wb_en && int'(wb_addr) == r);
  endfunction

  function automatic bit m_ready();
    bit stall;
    stall = m_waiting(int'(in_rs1)) || (!in_use_imm && m_waiting(int'(in_rs2)));
    return !stall && (!m_valid || alu_ready);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        m_rf[i]   <= 16'h0000;
        m_pend[i] <= 1'b0;
      end
      m_valid <= 1'b0;
      m_in1   <= '0;
      m_in2   <= '0;
      m_op    <= '0;
      m_rd    <= '0;
    end else begin
      if (wb_en && wb_addr != 0) m_rf[wb_addr] <= wb_data;
      if (in_valid && m_ready()) begin
        m_valid <= 1'b1;
        m_in1   <= m_read(int'(in_rs1));
        m_in2   <= in_use_imm ? 16'($signed(in_imm)) : m_read(int'(in_rs2));
        m_op    <= in_op;
        m_rd    <= in_rd;
        if (in_rd != 0) m_pend[in_rd] <= 1'b1;
        if (wb_en && wb_addr != in_rd) m_pend[wb_addr] <= 1'b0;
      end else begin
        if (alu_ready) m_valid <= 1'b0;
        if (wb_en) m_pend[wb_addr] <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("model_in_ready", 16'(in_ready), 16'(m_ready()));
    chk("model_alu_valid", 16'(alu_valid), 16'(m_valid));
    chk("model_alu_in1", alu_in1, m_in1);
    chk("model_alu_in2", alu_in2, m_in2);
    chk("model_alu_op", 16'(alu_op), 16'(m_op));
    chk("model_alu_rd", 16'(alu_rd), 16'(m_rd));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
    in_imm = 0; in_use_imm = 0; in_op = 0;
    wb_en = 0; wb_addr = 0; wb_data = 0;
  endtask

  task automatic issue(input logic [3:0] op, input int rs1, input int rs2, input int rd,
                       input logic [7:0] imm, input bit use_imm);
    in_valid = 1; in_op = op; in_rs1 = AW'(rs1); in_rs2 = AW'(rs2);
    in_rd = AW'(rd); in_imm = imm; in_use_imm = use_imm;
  endtask

  task automatic wb(input int a, input logic [15:0] d);
    wb_en = 1; wb_addr = AW'(a); wb_data = d;
  endtask

  initial begin
    idle();
    alu_ready = 1;
    rst_n = 0;
    #3;
    chk("rst_alu_valid", 16'(alu_valid), 16'h0);
    chk("rst_alu_in1", alu_in1, 16'h0);
    chk("rst_alu_rd", 16'(alu_rd), 16'h0);
    #9 rst_n = 1;

    // ADD r0 + sext(FF)
    tick();
    issue(FUNCT_ADD, 0, 0, 0, 8'hFF, 1);
    @(negedge clk); chk("t1_in_ready", 16'(in_ready), 16'h1);
    tick(); idle();
    @(negedge clk);
    chk("t1_valid", 16'(alu_valid), 16'h1);
    chk("t1_in1", alu_in1, 16'h0000);
    chk("t1_in2", alu_in2, 16'hFFFF);
    chk("t1_op", 16'(alu_op), 16'(FUNCT_ADD));
    chk("t1_in_ready", 16'(in_ready), 16'h1);

    // Bypass of r3 written in the issue cycle; rd=4 becomes pending
    tick();
    wb(3, 16'h1234); issue(4'd1, 3, 3, 4, 8'h00, 0);
    tick(); idle();
    @(negedge clk);
    chk("t2_in1", alu_in1, 16'h1234);
    chk("t2_in2", alu_in2, 16'h1234);
    chk("t2_rd", 16'(alu_rd), 16'h4);
    tick();
    in_rs1 = 4; in_use_imm = 1;
    @(negedge clk); chk("t2_pend4_stall", 16'(in_ready), 16'h0);
    tick();
    wb(4, 16'h0044);
    @(negedge clk); chk("t2_pend4_wb_release", 16'(in_ready), 16'h1);
    tick(); idle();

    // RAW stall on r5 released by its writeback
    issue(4'd2, 0, 0, 5, 8'h01, 1);
    tick();
    issue(4'd3, 5, 0, 6, 8'h00, 1);
    @(negedge clk); chk("t3_stall_a", 16'(in_ready), 16'h0);
    tick();
    @(negedge clk);
    chk("t3_stall_b", 16'(in_ready), 16'h0);
    chk("t3_drained", 16'(alu_valid), 16'h0);
    tick();
    wb(5, 16'h00AA);
    @(negedge clk); chk("t3_wb_ready", 16'(in_ready), 16'h1);
    tick(); idle();
    @(negedge clk);
    chk("t3_in1", alu_in1, 16'h00AA);
    chk("t3_rd", 16'(alu_rd), 16'h6);
    tick();
    wb(6, 16'h0066);
    tick(); idle();

    // Backpressure: bundle held for 3 cycles, then drain and accept together
    alu_ready = 0;
    issue(4'd3, 3, 0, 0, 8'h07, 1);
    tick();
    issue(4'd4, 5, 0, 0, 8'hFE, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_hold_ready", 16'(in_ready), 16'h0);
      chk("t4_hold_in1", alu_in1, 16'h1234);
      chk("t4_hold_in2", alu_in2, 16'h0007);
      tick();
    end
    alu_ready = 1;
    @(negedge clk); chk("t4_drain_ready", 16'(in_ready), 16'h1);
    tick(); idle();
    @(negedge clk);
    chk("t4_b2b_valid", 16'(alu_valid), 16'h1);
    chk("t4_b2b_in1", alu_in1, 16'h00AA);
    chk("t4_b2b_in2", alu_in2, 16'hFFFE);
    chk("t4_b2b_op", 16'(alu_op), 16'h4);
    tick();
    @(negedge clk); chk("t4_empty", 16'(alu_valid), 16'h0);

    // r0 is never written or pending
    tick();
    wb(0, 16'hFFFF);
    tick(); idle();
    issue(4'd5, 0, 0, 0, 8'h00, 0);
    tick();
    @(negedge clk);
    chk("t5_r0_in1", alu_in1, 16'h0000);
    chk("t5_r0_in2", alu_in2, 16'h0000);
    chk("t5_no_stall", 16'(in_ready), 16'h1);
    tick(); idle();

    // Collision: set of pending[7] beats the same-cycle clear
    issue(4'd6, 0, 0, 7, 8'h00, 1);
    wb(7, 16'h0777);
    tick(); idle();
    in_rs1 = 7; in_use_imm = 1;
    @(negedge clk); chk("t5_set_wins", 16'(in_ready), 16'h0);
    tick();
    wb(7, 16'h0778);
    tick(); idle();

    // Throughput table: fill registers, then back-to-back issues
    for (int i = 1; i < NREGS; i++) begin
      wb(i, 16'(16'h1111 * i));
      tick();
    end
    idle();
    for (int i = 1; i < NREGS; i++) begin
      issue(4'(i), i, (i + 3) % NREGS, 0, 8'(i * 37), i[0]);
      tick();
    end
    idle();
    @(negedge clk);
    chk("tab_last_in1", alu_in1, 16'h7777);
    chk("tab_last_in2", alu_in2, 16'h0003);
    tick();

    // Reset while a bundle is held and r2 is pending
    alu_ready = 0;
    issue(4'd7, 3, 0, 2, 8'h00, 1);
    tick(); idle();
    @(negedge clk);
    chk("t6_pre_valid", 16'(alu_valid), 16'h1);
    #2 rst_n = 0;
    #1;
    chk("t6_rst_valid", 16'(alu_valid), 16'h0);
    chk("t6_rst_in1", alu_in1, 16'h0000);
    @(posedge clk);
    #3 rst_n = 1;
    alu_ready = 1;
    issue(4'd8, 2, 3, 0, 8'h00, 0);
    @(negedge clk); chk("t6_no_stall", 16'(in_ready), 16'h1);
    tick(); idle();
    @(negedge clk);
    chk("t6_valid", 16'(alu_valid), 16'h1);
    chk("t6_r2_zero", alu_in1, 16'h0000);
    chk("t6_r3_zero", alu_in2, 16'h0000);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Issue stage directly upstream of the 16-bit ALU.
- Holds the architectural register file and reads two source operands, or one register plus a sign-extended immediate.
- Tracks pending writes with a scoreboard and stalls on read-after-write hazards.
- Presents a registered {in1, in2, op, rd} bundle to the ALU over a valid/ready handshake. The writeback port returns results into the register file.

Parameters:
- NREGS, 8, number of 16-bit registers; r0 reads as 0 and is never written or marked pending.
- AW, 3, register address width; must equal clog2(NREGS).
- IMM_W, 8, immediate width; sign-extended to 16 bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  instruction accepted this cycle when in_valid && in_ready.
- in_rs1  in  AW  source register 1.
- in_rs2  in  AW  source register 2; ignored when in_use_imm=1.
- in_rd  in  AW  destination register; 0 means no writeback.
- in_imm  in  IMM_W  immediate.
- in_use_imm  in  1  1: in2 = sext(in_imm).
- in_op  in  4  FUNCT_* code from funct.vh; passed through unchanged.
- alu_valid  out  1  bundle valid.
- alu_ready  in  1  downstream accepts the bundle.
- alu_in1  out  16  operand 1.
- alu_in2  out  16  operand 2.
- alu_op  out  4  ALU op.
- alu_rd  out  AW  destination register carried with the bundle.
- wb_en  in  1  writeback strobe.
- wb_addr  in  AW  writeback register.
- wb_data  in  16  writeback value.

Behaviour:
- Reset (async assert, sync release):
  - All registers are 0 and all pending bits are 0.
  - alu_valid=0; alu_in1, alu_in2, alu_op and alu_rd are 0.
  - A reset asserted mid-operation drops any held bundle; no partial state survives.
- Register file:
  - Write on a clk edge when wb_en && wb_addr!=0.
  - Reads are combinational, with a write-through bypass: if wb_en && wb_addr==rs && rs!=0, the read returns wb_data in the same cycle.
  - Reading r0 always returns 0.
- Scoreboard:
  - One pending bit per register.
  - Set pending[in_rd] on accept when in_rd!=0.
  - Clear pending[wb_addr] on wb_en.
  - If a set and a clear hit the same register in one cycle, the set wins (the newer producer is outstanding).
  - wb_en to a non-pending register still writes the register; the scoreboard is unchanged.
- Hazard:
  - hazard = (pending[rs1] && !(wb_en && wb_addr==rs1)) || (!in_use_imm && pending[rs2] && !(wb_en && wb_addr==rs2)).
  - Sources equal to r0 never cause a hazard.
  - in_rd pending (WAW) is not a hazard; in-order writeback is guaranteed by the pipeline.
- Handshake:
  - in_ready = !hazard && (!alu_valid || alu_ready).
  - in_ready may depend combinationally on the in_* fields and wb_*, but not on in_valid.
  - On accept, the output registers load the following values, with alu_valid=1 on the next cycle:
    - alu_in1 = read(rs1).
    - alu_in2 = in_use_imm ? sext(in_imm) : read(rs2).
    - alu_op = in_op; alu_rd = in_rd.
  - If alu_valid && alu_ready && !accept, alu_valid goes to 0.
  - While alu_valid && !alu_ready, all alu_* outputs hold stable.
- Latency: 1 cycle from accept to alu_valid; full throughput of 1 instruction per cycle with no hazards and alu_ready=1.
- Arithmetic: immediate sign-extension replicates bit IMM_W-1; no other arithmetic occurs in this block.

Test Plan:
- Reset, then issue op=ADD, rs1=0, use_imm=1, imm=8'hFF -> next cycle alu_valid=1, alu_in1=0, alu_in2=16'hFFFF, op=ADD; in_ready stays 1.
- Write wb r3=16'h1234; issue rs1=3, rs2=3, rd=4 in the same cycle as that write -> bypass gives alu_in1=alu_in2=16'h1234; pending[4]=1.
- Issue rd=5, then immediately issue rs1=5 -> in_ready=0 until wb_en with wb_addr=5 and wb_data=16'h00AA; accept happens in that wb cycle with alu_in1=16'h00AA.
- Hold alu_ready=0 for 3 cycles with a bundle held -> alu_* stable, in_ready=0; release -> a back-to-back accept occurs in the same cycle as the drain.
- wb_en with wb_addr=0 and wb_data=16'hFFFF, then read r0 -> 0; issue rd=0 -> no pending bit set; a following rs1=0 is not stalled.
- Assert rst_n=0 while alu_valid=1 and pending[2]=1 -> immediately alu_valid=0; after release, rs1=2 issues without stall and reads 0.
